// File: rtl/alu_op_pkg.sv
// rtl/alu_op_pkg.sv - ALU operation codes, ALUOp/Funct7 encodings and issue payload type
package alu_op_pkg;

    localparam int OP_W  = 4;
    localparam int TAG_W = 5;

    localparam logic [OP_W-1:0] OP_AND     = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR      = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD     = 4'b0010;
    localparam logic [OP_W-1:0] OP_SLL     = 4'b0100;
    localparam logic [OP_W-1:0] OP_SRL     = 4'b0101;
    localparam logic [OP_W-1:0] OP_XOR     = 4'b0110;
    localparam logic [OP_W-1:0] OP_SRA     = 4'b0111;
    localparam logic [OP_W-1:0] OP_BEQ     = 4'b1000;
    localparam logic [OP_W-1:0] OP_BNE     = 4'b1001;
    localparam logic [OP_W-1:0] OP_LTU     = 4'b1010;
    localparam logic [OP_W-1:0] OP_GEU     = 4'b1011;
    localparam logic [OP_W-1:0] OP_LT      = 4'b1100;
    localparam logic [OP_W-1:0] OP_SUB     = 4'b1101;
    localparam logic [OP_W-1:0] OP_ILLEGAL = 4'b1111;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic             br_invert;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } issue_t;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational ALUOp/Funct3/Funct7 to ALU operation decoder
module alu_op_decode
    import alu_op_pkg::*;
(
    input  logic [1:0]      aluop,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    output logic [OP_W-1:0] op,
    output logic            br_invert,
    output logic            illegal
);

    logic is_i;
    logic f7_base;
    logic f7_alt;
    logic bad;

    always_comb begin
        op        = OP_ADD;
        br_invert = 1'b0;
        bad       = 1'b0;
        is_i      = (aluop == ALUOP_I);
        f7_base   = (funct7 == F7_BASE);
        f7_alt    = (funct7 == F7_ALT);
        case (aluop)
            ALUOP_MEM: op = OP_ADD;
            ALUOP_BR: begin
                case (funct3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_LT;
                    // BGE reuses signed less-than; the branch unit inverts the result
                    3'b101:  begin op = OP_LT; br_invert = 1'b1; end
                    3'b110:  op = OP_LTU;
                    3'b111:  op = OP_GEU;
                    default: bad = 1'b1;
                endcase
            end
            default: begin
                // Immediate forms have no funct7 except on shifts
                case (funct3)
                    3'b000: begin
                        if (is_i || f7_base) op = OP_ADD;
                        else if (f7_alt)     op = OP_SUB;
                        else                 bad = 1'b1;
                    end
                    3'b111: begin op = OP_AND; bad = !(is_i || f7_base); end
                    3'b110: begin op = OP_OR;  bad = !(is_i || f7_base); end
                    3'b100: begin op = OP_XOR; bad = !(is_i || f7_base); end
                    3'b010: begin op = OP_LT;  bad = !(is_i || f7_base); end
                    3'b011: begin op = OP_LTU; bad = !(is_i || f7_base); end
                    3'b001: begin op = OP_SLL; bad = !f7_base; end
                    default: begin
                        if (f7_base)     op = OP_SRL;
                        else if (f7_alt) op = OP_SRA;
                        else             bad = 1'b1;
                    end
                endcase
            end
        endcase
        if (bad) begin
            op        = OP_ILLEGAL;
            br_invert = 1'b0;
        end
        illegal = bad;
    end

endmodule

// File: rtl/alu_op_issue.sv
// rtl/alu_op_issue.sv - registered ALU op issue stage with 2-entry skid buffer
module alu_op_issue
    import alu_op_pkg::*;
#(
    parameter int OPCODE_LENGTH = 4,
    parameter int TAG_WIDTH     = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     br_invert,
    output logic                     illegal,
    output logic [TAG_WIDTH-1:0]     out_tag
);

    issue_t a_q, a_d;
    issue_t b_q, b_d;
    issue_t new_entry;
    logic   a_valid_q, a_valid_d;
    logic   b_valid_q, b_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept;
    logic   pop;

    logic [OP_W-1:0] dec_op;
    logic            dec_br_invert;
    logic            dec_illegal;

    alu_op_decode u_decode (
        .aluop     (ALUOp),
        .funct3    (Funct3),
        .funct7    (Funct7),
        .op        (dec_op),
        .br_invert (dec_br_invert),
        .illegal   (dec_illegal)
    );

    always_comb begin
        new_entry           = '0;
        new_entry.op        = dec_op;
        new_entry.br_invert = dec_br_invert;
        new_entry.illegal   = dec_illegal;
        new_entry.tag       = in_tag;

        accept    = in_valid & in_ready_q;
        pop       = a_valid_q & out_ready;
        a_d       = a_q;
        b_d       = b_q;
        a_valid_d = a_valid_q;
        b_valid_d = b_valid_q;

        // Payloads are left untouched on flush; only the valid bits drop
        if (flush) begin
            a_valid_d = 1'b0;
            b_valid_d = 1'b0;
        end else begin
            if (pop) begin
                if (b_valid_q) begin
                    a_d       = b_q;
                    a_valid_d = 1'b1;
                    b_valid_d = 1'b0;
                end else begin
                    a_valid_d = 1'b0;
                end
            end
            // accept implies B is empty, so it never collides with the B->A move
            if (accept) begin
                if (!a_valid_q || pop) begin
                    a_d       = new_entry;
                    a_valid_d = 1'b1;
                end else begin
                    b_d       = new_entry;
                    b_valid_d = 1'b1;
                end
            end
        end
        in_ready_d = !b_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q        <= '0;
            b_q        <= '0;
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            a_valid_q  <= a_valid_d;
            b_valid_q  <= b_valid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = a_valid_q;
    assign Operation = a_q.op;
    assign br_invert = a_q.br_invert;
    assign illegal   = a_q.illegal;
    assign out_tag   = a_q.tag;

endmodule

// File: tb/tb_alu_op_issue.sv
// tb/tb_alu_op_issue.sv - self-checking bench for alu_op_issue
module tb_alu_op_issue;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] in_tag;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] operation;
    logic       br_invert;
    logic       illegal;
    logic [4:0] out_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_op_issue dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOp     (alu_op),
        .Funct3    (funct3),
        .Funct7    (funct7),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Operation (operation),
        .br_invert (br_invert),
        .illegal   (illegal),
        .out_tag   (out_tag)
    );

    typedef struct packed {
        logic [3:0] op;
        logic       inv;
        logic       ill;
        logic [4:0] tag;
    } ent_t;

    typedef struct {
        logic [1:0] aluop;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] tag;
        logic [3:0] op;
        logic       inv;
        logic       ill;
    } vec_t;

    vec_t vecs [16];
    ent_t mq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] a, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] t);
        in_valid = v;
        alu_op   = a;
        funct3   = f3;
        funct7   = f7;
        in_tag   = t;
    endtask

    // Reference decode built from lookup tables indexed by funct3
    function automatic ent_t ref_dec(input logic [1:0] a, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [4:0] t);
        logic [3:0] br_tab [8];
        logic [3:0] ar_tab [8];
        logic       need_f7;
        ent_t       e;
        br_tab = '{4'd8, 4'd9, 4'd15, 4'd15, 4'd12, 4'd12, 4'd10, 4'd11};
        ar_tab = '{4'd2, 4'd4, 4'd12, 4'd10, 4'd6, 4'd5, 4'd1, 4'd0};
        e = '{op: 4'd2, inv: 1'b0, ill: 1'b0, tag: t};
        if (a == 2'd1) begin
            e.op  = br_tab[f3];
            e.ill = (f3 == 3'd2 || f3 == 3'd3);
            e.inv = (f3 == 3'd5);
        end else if (a != 2'd0) begin
            need_f7 = (a == 2'd2) || (f3 == 3'd1) || (f3 == 3'd5);
            if (!need_f7 || f7 == 7'd0)
                e.op = ar_tab[f3];
            else if (f7 == 7'd32 && f3 == 3'd0)
                e.op = 4'd13;
            else if (f7 == 7'd32 && f3 == 3'd5)
                e.op = 4'd7;
            else
                e.ill = 1'b1;
        end
        if (e.ill)
            e.op = 4'd15;
        return e;
    endfunction

    initial begin
        ent_t exp_e;
        logic acc;
        logic pp;

        vecs[0]  = '{2'b10, 3'b000, 7'h20, 5'd7,  4'b1101, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 3'b101, 7'h00, 5'd1,  4'b1100, 1'b1, 1'b0};
        vecs[2]  = '{2'b01, 3'b110, 7'h00, 5'd2,  4'b1010, 1'b0, 1'b0};
        vecs[3]  = '{2'b10, 3'b001, 7'h20, 5'd3,  4'b1111, 1'b0, 1'b1};
        vecs[4]  = '{2'b11, 3'b000, 7'h20, 5'd4,  4'b0010, 1'b0, 1'b0};
        vecs[5]  = '{2'b00, 3'b111, 7'h7f, 5'd5,  4'b0010, 1'b0, 1'b0};
        vecs[6]  = '{2'b01, 3'b000, 7'h00, 5'd6,  4'b1000, 1'b0, 1'b0};
        vecs[7]  = '{2'b01, 3'b011, 7'h00, 5'd8,  4'b1111, 1'b0, 1'b1};
        vecs[8]  = '{2'b10, 3'b101, 7'h20, 5'd9,  4'b0111, 1'b0, 1'b0};
        vecs[9]  = '{2'b11, 3'b101, 7'h00, 5'd10, 4'b0101, 1'b0, 1'b0};
        vecs[10] = '{2'b11, 3'b001, 7'h20, 5'd11, 4'b1111, 1'b0, 1'b1};
        vecs[11] = '{2'b10, 3'b111, 7'h01, 5'd12, 4'b1111, 1'b0, 1'b1};
        vecs[12] = '{2'b11, 3'b111, 7'h01, 5'd13, 4'b0000, 1'b0, 1'b0};
        vecs[13] = '{2'b10, 3'b010, 7'h00, 5'd14, 4'b1100, 1'b0, 1'b0};
        vecs[14] = '{2'b01, 3'b111, 7'h00, 5'd15, 4'b1011, 1'b0, 1'b0};
        vecs[15] = '{2'b10, 3'b110, 7'h00, 5'd16, 4'b0001, 1'b0, 1'b0};

        reset = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'd0, 3'd0, 7'd0, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_operation", operation, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].aluop, vecs[i].f3, vecs[i].f7, vecs[i].tag);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_entry", i), {operation, br_invert, illegal, out_tag},
                {vecs[i].op, vecs[i].inv, vecs[i].ill, vecs[i].tag});
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_out_valid", out_valid, 0);

        // Backpressure: two entries fill A and B
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 3'd0, 7'd0, 5'd1);
        @(negedge clk);
        chk("bp_tag1", out_tag, 1);
        chk("bp_ready1", in_ready, 1);
        drive(1'b1, 2'd0, 3'd0, 7'd0, 5'd2);
        @(negedge clk);
        chk("bp_ready_drop", in_ready, 0);
        chk("bp_hold1", out_tag, 1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_hold2", out_tag, 1);
        chk("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_tag2", out_tag, 2);
        chk("bp_valid2", out_valid, 1);
        chk("bp_ready_back", in_ready, 1);
        @(negedge clk);
        chk("bp_empty", out_valid, 0);

        // Flush with both entries full and a concurrent input
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 3'd0, 7'd0, 5'd3);
        @(negedge clk);
        drive(1'b1, 2'd0, 3'd0, 7'd0, 5'd4);
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, 2'd2, 3'd0, 7'h20, 5'd9);
        @(negedge clk);
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("fl_no_ghost", out_valid, 0);

        // Flush beats an accept while in_ready is high
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 3'd0, 7'd0, 5'd5);
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, 2'd0, 3'd0, 7'd0, 5'd10);
        @(negedge clk);
        chk("fl2_valid", out_valid, 0);
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("fl2_no_ghost", out_valid, 0);

        // Reset mid-operation beats flush and handshake
        drive(1'b1, 2'd1, 3'd5, 7'd0, 5'd20);
        @(negedge clk);
        drive(1'b1, 2'd1, 3'd5, 7'd0, 5'd21);
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("mrst_state", {out_valid, in_ready, operation, br_invert, illegal, out_tag},
            {1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 5'd0});
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        mq.delete();

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            chk("rand_out_valid", out_valid, (mq.size() != 0));
            chk("rand_in_ready", in_ready, (mq.size() < 2));
            if (mq.size() != 0)
                chk("rand_entry", {operation, br_invert, illegal, out_tag}, mq[0]);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            alu_op    = 2'($urandom_range(0, 3));
            funct3    = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0, 1:    funct7 = 7'd0;
                2:       funct7 = 7'd32;
                default: funct7 = 7'($urandom);
            endcase
            in_tag = 5'($urandom);
            exp_e  = ref_dec(alu_op, funct3, funct7, in_tag);
            acc    = in_valid && (mq.size() < 2);
            pp     = (mq.size() != 0) && out_ready;
            @(posedge clk);
            if (flush) begin
                mq.delete();
            end else begin
                if (pp)
                    void'(mq.pop_front());
                if (acc)
                    mq.push_back(exp_e);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
